// File: rtl/decoder2_4_seq_if.sv
// Handshake and one-hot output bundle for decoder2_4_seq.
interface decoder2_4_seq_if #(
  parameter int W = 2
);
  logic [W-1:0]        i;
  logic                valid;
  logic                ready;
  logic [(1<<W)-1:0]   o;
  logic                busy;
  logic                done;

  modport master (output i, valid, input ready, o, busy, done);
  modport slave  (input i, valid, output ready, o, busy, done);
endinterface

// File: rtl/decoder2_4_seq.sv
// Sequenced binary-to-one-hot decoder: holds the selected line for DWELL
// clocks, then all lines low for GAP clocks before accepting the next code.
module decoder2_4_seq #(
  parameter int W     = 2,
  parameter int DWELL = 4,
  parameter int GAP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  decoder2_4_seq_if.slave   bus
);
  localparam int N = 1 << W;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [W-1:0]   code_q, code_d;
  logic [N-1:0]   o_q, o_d;
  logic           done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      o_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      o_q     <= o_d;
      done_q  <= done_d;
    end
  end

  // done is registered, so it is raised on the edge entering the last DWELL cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    o_d     = o_q;
    done_d  = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      o_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          o_d = '0;
          if (bus.valid) begin
            code_d  = bus.i;
            cnt_d   = 8'(DWELL - 1);
            o_d     = N'(1) << bus.i;
            done_d  = (DWELL == 1);
            state_d = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == 8'd0) begin
            o_d = '0;
            if (GAP > 0) begin
              cnt_d   = 8'(GAP - 1);
              state_d = ST_GAP;
            end else begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d  = cnt_q - 8'd1;
            done_d = (cnt_q == 8'd1);
          end
        end
        ST_GAP: begin
          o_d = '0;
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          o_d     = '0;
        end
      endcase
    end
  end

  assign bus.ready = (state_q == ST_IDLE) && !clr;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.o     = o_q;
  assign bus.done  = done_q;
endmodule
